// File: rtl/vga_pkg.sv
// Video mode constant sets and count typedef shared by the raster timing generator.
package vga_pkg;

   localparam int VGA_CNT_MAX_W = 16;
   typedef logic [VGA_CNT_MAX_W-1:0] vga_cnt_t;

   typedef struct packed {
      vga_cnt_t h_active;
      vga_cnt_t h_fp;
      vga_cnt_t h_sync;
      vga_cnt_t h_bp;
      vga_cnt_t v_active;
      vga_cnt_t v_fp;
      vga_cnt_t v_sync;
      vga_cnt_t v_bp;
      logic     hs_pol;
      logic     vs_pol;
   } vga_mode_t;

   // 65 MHz pixel clock
   localparam vga_mode_t VGA_1024x768_60 = '{
      h_active: 16'd1024, h_fp: 16'd24, h_sync: 16'd136, h_bp: 16'd160,
      v_active: 16'd768,  v_fp: 16'd3,  v_sync: 16'd6,   v_bp: 16'd29,
      hs_pol: 1'b0, vs_pol: 1'b0};

   // 40 MHz pixel clock
   localparam vga_mode_t VGA_800x600_60 = '{
      h_active: 16'd800, h_fp: 16'd40, h_sync: 16'd128, h_bp: 16'd88,
      v_active: 16'd600, v_fp: 16'd1,  v_sync: 16'd4,   v_bp: 16'd23,
      hs_pol: 1'b1, vs_pol: 1'b1};

   // 25 MHz pixel rate, reached through ce
   localparam vga_mode_t VGA_640x480_60 = '{
      h_active: 16'd640, h_fp: 16'd16, h_sync: 16'd96, h_bp: 16'd48,
      v_active: 16'd480, v_fp: 16'd10, v_sync: 16'd2,  v_bp: 16'd33,
      hs_pol: 1'b0, vs_pol: 1'b0};

   function automatic int vga_total(input int act, input int fp, input int sync, input int bp);
      return act + fp + sync + bp;
   endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: ce flows into the generator, counts/flags/strobes flow out.
interface vga_timing_gen_if #(
   parameter int CNT_W   = 11,
   parameter int FRAME_W = 16
);
   logic               ce;
   logic [CNT_W-1:0]   hcount;
   logic [CNT_W-1:0]   vcount;
   logic               hsync;
   logic               vsync;
   logic               hblnk;
   logic               vblnk;
   logic               line_start;
   logic               frame_start;
   logic [FRAME_W-1:0] frame_cnt;

   modport master (
      input  ce,
      output hcount, vcount, hsync, vsync, hblnk, vblnk,
             line_start, frame_start, frame_cnt
   );

   modport slave (
      output ce,
      input  hcount, vcount, hsync, vsync, hblnk, vblnk,
             line_start, frame_start, frame_cnt
   );
endinterface

// File: rtl/vga_axis_ctr.sv
// One raster axis: modulo counter with increment-enable; blank and sync are
// decoded from the next count so they stay aligned with the registered count.
module vga_axis_ctr #(
   parameter int ACTIVE = 1,
   parameter int FP     = 1,
   parameter int SYNC   = 1,
   parameter int BP     = 1,
   parameter bit POL    = 1'b0,
   parameter int W      = 11
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] cnt,
   output logic         wrap,
   output logic         blank,
   output logic         sync
);
   localparam int           TOT     = ACTIVE + FP + SYNC + BP;
   localparam logic [W-1:0] LAST    = W'(TOT - 1);
   localparam logic [W-1:0] ACT     = W'(ACTIVE);
   localparam logic [W-1:0] SYNC_LO = W'(ACTIVE + FP);
   localparam logic [W-1:0] SYNC_HI = W'(ACTIVE + FP + SYNC - 1);

   logic [W-1:0] cnt_q, cnt_d;
   logic         blank_q, blank_d;
   logic         sync_q, sync_d;

   always_comb begin
      wrap  = inc && (cnt_q == LAST);
      cnt_d = cnt_q;
      if (wrap) begin
         cnt_d = '0;
      end else if (inc) begin
         cnt_d = cnt_q + W'(1);
      end
      blank_d = (cnt_d >= ACT);
      sync_d  = ((cnt_d >= SYNC_LO) && (cnt_d <= SYNC_HI)) ? POL : ~POL;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         blank_q <= 1'b0;
         sync_q  <= ~POL;
      end else begin
         cnt_q   <= cnt_d;
         blank_q <= blank_d;
         sync_q  <= sync_d;
      end
   end

   assign cnt   = cnt_q;
   assign blank = blank_q;
   assign sync  = sync_q;
endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing: H axis advances on ce, V axis on the H wrap;
// all outputs registered with zero skew, strobes fire only on ce-qualified wraps.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = int'(VGA_1024x768_60.h_active),
   parameter int H_FP     = int'(VGA_1024x768_60.h_fp),
   parameter int H_SYNC   = int'(VGA_1024x768_60.h_sync),
   parameter int H_BP     = int'(VGA_1024x768_60.h_bp),
   parameter int V_ACTIVE = int'(VGA_1024x768_60.v_active),
   parameter int V_FP     = int'(VGA_1024x768_60.v_fp),
   parameter int V_SYNC   = int'(VGA_1024x768_60.v_sync),
   parameter int V_BP     = int'(VGA_1024x768_60.v_bp),
   parameter bit HS_POL   = VGA_1024x768_60.hs_pol,
   parameter bit VS_POL   = VGA_1024x768_60.vs_pol,
   parameter int CNT_W    = 11,
   parameter int FRAME_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   vga_timing_gen_if.master  vif
);
   localparam int H_TOT   = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOT   = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
   localparam int MAX_TOT = (H_TOT > V_TOT) ? H_TOT : V_TOT;

   if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
       V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_timing
      $error("vga_timing_gen: every timing parameter must be >= 1");
   end
   if (CNT_W < 1 || (CNT_W < 31 && (1 << CNT_W) <= MAX_TOT)) begin : g_bad_cnt_w
      $error("vga_timing_gen: CNT_W too narrow for the line/frame totals");
   end
   if (FRAME_W < 1) begin : g_bad_frame_w
      $error("vga_timing_gen: FRAME_W must be >= 1");
   end

   logic [CNT_W-1:0]   hcnt, vcnt;
   logic               h_wrap, v_wrap;
   logic               hblnk, vblnk, hsync, vsync;
   logic               line_start_q, line_start_d;
   logic               frame_start_q, frame_start_d;
   logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;

   vga_axis_ctr #(
      .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HS_POL), .W(CNT_W)
   ) u_h_ctr (
      .clk(clk), .rst(rst), .inc(vif.ce),
      .cnt(hcnt), .wrap(h_wrap), .blank(hblnk), .sync(hsync)
   );

   // V only moves on the H wrap, so vsync can only change as hcount enters 0.
   vga_axis_ctr #(
      .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VS_POL), .W(CNT_W)
   ) u_v_ctr (
      .clk(clk), .rst(rst), .inc(h_wrap),
      .cnt(vcnt), .wrap(v_wrap), .blank(vblnk), .sync(vsync)
   );

   always_comb begin
      line_start_d  = h_wrap;
      frame_start_d = v_wrap;
      frame_cnt_d   = frame_cnt_q + FRAME_W'(v_wrap);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
         frame_cnt_q   <= '0;
      end else begin
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
         frame_cnt_q   <= frame_cnt_d;
      end
   end

   assign vif.hcount      = hcnt;
   assign vif.vcount      = vcnt;
   assign vif.hsync       = hsync;
   assign vif.vsync       = vsync;
   assign vif.hblnk       = hblnk;
   assign vif.vblnk       = vblnk;
   assign vif.line_start  = line_start_q;
   assign vif.frame_start = frame_start_q;
   assign vif.frame_cnt   = frame_cnt_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench: default 1024x768 instance for line timing, tiny instance for frame/wrap behaviour.
module tb_vga_timing_gen;

   localparam int HA [2] = '{1024, 8};
   localparam int HF [2] = '{24, 1};
   localparam int HS [2] = '{136, 2};
   localparam int HB [2] = '{160, 1};
   localparam int VA [2] = '{768, 4};
   localparam int VF [2] = '{3, 1};
   localparam int VS [2] = '{6, 1};
   localparam int VB [2] = '{29, 1};
   localparam int HP [2] = '{0, 1};
   localparam int VP [2] = '{0, 1};
   localparam int FW [2] = '{16, 2};

   typedef struct {
      int h; int v; int hs; int vs; int hb; int vb; int ls; int fs; int fc;
   } obs_t;

   typedef struct {
      int at; int h; int v; int hb; int hs; int ls;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a, rst_b;
   vga_timing_gen_if #(.CNT_W(11), .FRAME_W(16)) if_a ();
   vga_timing_gen_if #(.CNT_W(4),  .FRAME_W(2))  if_b ();

   vga_timing_gen dut_a (.clk(clk), .rst(rst_a), .vif(if_a));
   vga_timing_gen #(
      .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HS_POL(1), .VS_POL(1), .CNT_W(4), .FRAME_W(2)
   ) dut_b (.clk(clk), .rst(rst_b), .vif(if_b));

   int errors = 0;
   int checks = 0;
   int m_pos [2];
   int m_frm [2];
   int m_ls [2];
   int m_fs [2];

   function automatic int ht(input int d); return HA[d] + HF[d] + HS[d] + HB[d]; endfunction
   function automatic int vt(input int d); return VA[d] + VF[d] + VS[d] + VB[d]; endfunction

   // Reference: a frame is a flat sequence of ht*vt pixel slots; ce moves one slot.
   function automatic void model_edge(input int d, input logic r, input logic c);
      if (r) begin
         m_pos[d] = 0; m_frm[d] = 0; m_ls[d] = 0; m_fs[d] = 0;
      end else if (c) begin
         m_pos[d] = (m_pos[d] + 1) % (ht(d) * vt(d));
         m_ls[d]  = ((m_pos[d] % ht(d)) == 0) ? 1 : 0;
         m_fs[d]  = (m_pos[d] == 0) ? 1 : 0;
         if (m_fs[d] == 1) m_frm[d]++;
      end else begin
         m_ls[d] = 0; m_fs[d] = 0;
      end
   endfunction

   function automatic obs_t model_exp(input int d);
      obs_t e;
      int h, v;
      h = m_pos[d] % ht(d);
      v = m_pos[d] / ht(d);
      e.h  = h;
      e.v  = v;
      e.hb = (h >= HA[d]) ? 1 : 0;
      e.vb = (v >= VA[d]) ? 1 : 0;
      e.hs = (h >= HA[d] + HF[d] && h < HA[d] + HF[d] + HS[d]) ? HP[d] : 1 - HP[d];
      e.vs = (v >= VA[d] + VF[d] && v < VA[d] + VF[d] + VS[d]) ? VP[d] : 1 - VP[d];
      e.ls = m_ls[d];
      e.fs = m_fs[d];
      e.fc = m_frm[d] % (1 << FW[d]);
      return e;
   endfunction

   function automatic obs_t obs_a();
      obs_t o;
      o.h = int'(if_a.hcount); o.v = int'(if_a.vcount);
      o.hs = int'(if_a.hsync); o.vs = int'(if_a.vsync);
      o.hb = int'(if_a.hblnk); o.vb = int'(if_a.vblnk);
      o.ls = int'(if_a.line_start); o.fs = int'(if_a.frame_start);
      o.fc = int'(if_a.frame_cnt);
      return o;
   endfunction

   function automatic obs_t obs_b();
      obs_t o;
      o.h = int'(if_b.hcount); o.v = int'(if_b.vcount);
      o.hs = int'(if_b.hsync); o.vs = int'(if_b.vsync);
      o.hb = int'(if_b.hblnk); o.vb = int'(if_b.vblnk);
      o.ls = int'(if_b.line_start); o.fs = int'(if_b.frame_start);
      o.fc = int'(if_b.frame_cnt);
      return o;
   endfunction

   function automatic void chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endfunction

   function automatic void cmp_obs(input string tag, input obs_t a, input obs_t e);
      chk({tag, ".hcount"}, a.h, e.h);
      chk({tag, ".vcount"}, a.v, e.v);
      chk({tag, ".hsync"}, a.hs, e.hs);
      chk({tag, ".vsync"}, a.vs, e.vs);
      chk({tag, ".hblnk"}, a.hb, e.hb);
      chk({tag, ".vblnk"}, a.vb, e.vb);
      chk({tag, ".line_start"}, a.ls, e.ls);
      chk({tag, ".frame_start"}, a.fs, e.fs);
      chk({tag, ".frame_cnt"}, a.fc, e.fc);
   endfunction

   task automatic tick();
      @(posedge clk);
      model_edge(0, rst_a, if_a.ce);
      model_edge(1, rst_b, if_b.ce);
      #1;
      cmp_obs("model_a", obs_a(), model_exp(0));
      cmp_obs("model_b", obs_b(), model_exp(1));
   endtask

   vec_t tbl [10];
   int   n, pulses, last, cyc, wide, prev_ls;

   initial begin
      #50_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{1,    1,    0, 0, 1, 0};
      tbl[1] = '{1023, 1023, 0, 0, 1, 0};
      tbl[2] = '{1024, 1024, 0, 1, 1, 0};
      tbl[3] = '{1047, 1047, 0, 1, 1, 0};
      tbl[4] = '{1048, 1048, 0, 1, 0, 0};
      tbl[5] = '{1183, 1183, 0, 1, 0, 0};
      tbl[6] = '{1184, 1184, 0, 1, 1, 0};
      tbl[7] = '{1343, 1343, 0, 1, 1, 0};
      tbl[8] = '{1344, 0,    1, 0, 1, 1};
      tbl[9] = '{1345, 1,    1, 0, 1, 0};

      m_pos = '{0, 0}; m_frm = '{0, 0}; m_ls = '{0, 0}; m_fs = '{0, 0};
      rst_a = 1'b1; rst_b = 1'b1; if_a.ce = 1'b1; if_b.ce = 1'b1;
      repeat (5) tick();
      chk("rst_hcount", int'(if_a.hcount), 0);
      chk("rst_vcount", int'(if_a.vcount), 0);
      chk("rst_hsync", int'(if_a.hsync), 1);
      chk("rst_vsync", int'(if_a.vsync), 1);
      chk("rst_hblnk", int'(if_a.hblnk), 0);
      chk("rst_strobes", int'({if_a.line_start, if_a.frame_start}), 0);
      chk("rst_frame_cnt", int'(if_a.frame_cnt), 0);
      chk("rst_b_hsync", int'(if_b.hsync), 0);

      // Line timing of the default mode at full rate.
      rst_a = 1'b0;
      n = 0;
      for (int i = 0; i < 10; i++) begin
         while (n < tbl[i].at) begin tick(); n++; end
         chk($sformatf("vec%0d.hcount", i), int'(if_a.hcount), tbl[i].h);
         chk($sformatf("vec%0d.vcount", i), int'(if_a.vcount), tbl[i].v);
         chk($sformatf("vec%0d.hblnk", i), int'(if_a.hblnk), tbl[i].hb);
         chk($sformatf("vec%0d.hsync", i), int'(if_a.hsync), tbl[i].hs);
         chk($sformatf("vec%0d.line_start", i), int'(if_a.line_start), tbl[i].ls);
      end

      pulses = 0;
      repeat (4 * 1344) begin
         tick();
         if (if_a.line_start) begin
            pulses++;
            chk("ls_at_h0", int'(if_a.hcount), 0);
         end
      end
      chk("ls_per_4_lines", pulses, 4);

      // ce at 1-of-2: line period doubles, strobes stay single-clock.
      pulses = 0; last = -1; cyc = 0; wide = 0; prev_ls = 0;
      for (int k = 0; k < 3 * 2688; k++) begin
         if_a.ce = (k % 2 == 0);
         tick();
         cyc++;
         if (if_a.line_start) begin
            pulses++;
            if (last >= 0) chk("ce_half_period", cyc - last, 2688);
            last = cyc;
            if (prev_ls != 0) wide++;
         end
         prev_ls = int'(if_a.line_start);
      end
      chk("ce_half_pulses", (pulses >= 2) ? 1 : 0, 1);
      chk("ce_half_wide", wide, 0);

      // Mid-line reset coinciding with ce.
      if_a.ce = 1'b1;
      for (int k = 0; k < 2000 && int'(if_a.hcount) != 500; k++) tick();
      chk("reach_h500", int'(if_a.hcount), 500);
      rst_a = 1'b1;
      tick();
      chk("midrst_hcount", int'(if_a.hcount), 0);
      chk("midrst_vcount", int'(if_a.vcount), 0);
      chk("midrst_strobes", int'({if_a.line_start, if_a.frame_start}), 0);
      chk("midrst_syncs", int'({if_a.hsync, if_a.vsync}), 3);
      rst_a = 1'b0;
      tick();
      chk("midrst_resume", int'(if_a.hcount), 1);
      if_a.ce = 1'b0;

      // Tiny mode: random ce and occasional reset against the reference.
      rst_b = 1'b0;
      repeat (1500) begin
         if_b.ce = ($urandom_range(0, 3) != 0);
         rst_b   = ($urandom_range(0, 149) == 0);
         tick();
      end

      // Tiny mode: frame counter wraps 3 -> 0 then continues.
      rst_b = 1'b1;
      tick();
      rst_b = 1'b0; if_b.ce = 1'b1;
      repeat (336) tick();
      chk("wrap4.frame_start", int'(if_b.frame_start), 1);
      chk("wrap4.frame_cnt", int'(if_b.frame_cnt), 0);
      chk("wrap4.pos", int'({if_b.hcount, if_b.vcount}), 0);
      repeat (84) tick();
      chk("wrap5.frame_start", int'(if_b.frame_start), 1);
      chk("wrap5.frame_cnt", int'(if_b.frame_cnt), 1);
      chk("wrap5.line_start", int'(if_b.line_start), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
